// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//
// SPI mode-0 master (CPOL=0, CPHA=0). Each accepted start shifts one DATA_W-bit
// word out on mosi, MSB first, and captures one word from miso. With hold_cs
// set, cs_n stays low after the word so several words form one burst.
//
// Handshake: start_i is a request that is taken only when busy_o=0 and no done
// pulse is showing. tx_data_i and hold_cs_i are sampled in the cycle start_i is
// taken. done_o is a one-cycle pulse marking rx_data_o valid; rx_data_o then
// holds until the next done_o. abort_i wins over start_i in the same cycle.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous reset, active high
//   start_i      transfer request
//   tx_data_i    word to send
//   hold_cs_i    1 = keep cs_n low after this word
//   abort_i      terminate the current transfer at once
//   miso_i       slave data in (sampled directly in the clk domain)
//   busy_o       transfer in progress (SETUP, LOW, HIGH, HOLD)
//   done_o       one-cycle pulse, rx_data_o valid
//   rx_data_o    last received word
//   sclk_o       SPI clock, idle low
//   cs_n_o       chip select, active low
//   mosi_o       master data out
//   dbg_state_o  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
   parameter int DATA_W   = 8,
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              hold_cs_i,
   input  logic              abort_i,
   input  logic              miso_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              sclk_o,
   output logic              cs_n_o,
   output logic              mosi_o,
   output logic [2:0]        dbg_state_o
);

   // Parameter legality, caught at elaboration.
   if (CLK_DIV < 2) begin : g_chk_clk_div
      $error("spi_master_ctrl: CLK_DIV must be >= 2");
   end
   if (CS_SETUP < 1) begin : g_chk_cs_setup
      $error("spi_master_ctrl: CS_SETUP must be >= 1");
   end
   if (CS_HOLD < 1) begin : g_chk_cs_hold
      $error("spi_master_ctrl: CS_HOLD must be >= 1");
   end
   if (DATA_W < 2) begin : g_chk_data_w
      $error("spi_master_ctrl: DATA_W must be >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_HOLD  = 3'd4,
      S_PAUSE = 3'd5
   } state_t;

   // One phase counter serves every timed state, so it is sized for the longest.
   localparam int CNT_MAX = (CLK_DIV > CS_SETUP)
                            ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                            : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int BIT_W   = $clog2(DATA_W);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
   localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(DATA_W - 1);

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [BIT_W-1:0]    bit_q;
   logic [DATA_W-1:0]   tx_sh_q;
   logic [DATA_W-1:0]   rx_sh_q;
   logic [DATA_W-1:0]   rx_data_q;
   logic                hold_q;
   logic                busy_q;
   logic                done_q;
   logic                sclk_q;
   logic                cs_n_q;
   logic                mosi_q;

   // Word sampled on the last HIGH cycle of the final bit.
   logic [DATA_W-1:0]   rx_word_d;
   assign rx_word_d = {rx_sh_q[DATA_W-2:0], miso_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  // The done cycle is still the tail of the previous word.
                  if (start_i && !done_q) begin
                     tx_sh_q <= tx_data_i;
                     hold_q  <= hold_cs_i;
                     mosi_q  <= tx_data_i[DATA_W-1];
                     bit_q   <= BIT_TOP;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     cs_n_q  <= 1'b0;
                     state_q <= S_SETUP;
                  end
               end
               S_SETUP: begin
                  if (cnt_q == SETUP_LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_LOW;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_LOW: begin
                  if (cnt_q == DIV_LAST) begin
                     cnt_q   <= '0;
                     sclk_q  <= 1'b1;
                     state_q <= S_HIGH;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_HIGH: begin
                  if (cnt_q == DIV_LAST) begin
                     cnt_q   <= '0;
                     sclk_q  <= 1'b0;
                     rx_sh_q <= rx_word_d;
                     if (bit_q == '0) begin
                        if (hold_q) begin
                           busy_q    <= 1'b0;
                           done_q    <= 1'b1;
                           rx_data_q <= rx_word_d;
                           state_q   <= S_PAUSE;
                        end else begin
                           state_q <= S_HOLD;
                        end
                     end else begin
                        // Next bit goes out as sclk falls (mode 0).
                        bit_q   <= bit_q - BIT_ONE;
                        tx_sh_q <= tx_sh_q << 1;
                        mosi_q  <= tx_sh_q[DATA_W-2];
                        state_q <= S_LOW;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_HOLD: begin
                  if (cnt_q == HOLD_LAST) begin
                     cnt_q     <= '0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     rx_data_q <= rx_sh_q;
                     cs_n_q    <= 1'b1;
                     mosi_q    <= 1'b0;
                     state_q   <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_PAUSE: begin
                  // cs_n is already low, so the burst continues straight into LOW.
                  if (start_i && !done_q) begin
                     tx_sh_q <= tx_data_i;
                     hold_q  <= hold_cs_i;
                     mosi_q  <= tx_data_i[DATA_W-1];
                     bit_q   <= BIT_TOP;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_LOW;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  sclk_q  <= 1'b0;
                  cs_n_q  <= 1'b1;
                  mosi_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign rx_data_o   = rx_data_q;
   assign sclk_o      = sclk_q;
   assign cs_n_o      = cs_n_q;
   assign mosi_o      = mosi_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Bench for spi_master_ctrl with default parameters. A mode-0 slave model
// drives miso (or miso is looped back from mosi). Expected words, latencies
// and mosi bit streams come from plain arithmetic on the word/burst rules.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

   localparam int DATA_W   = 8;
   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [DATA_W-1:0] tx_data;
   logic              hold_cs;
   logic              abort;
   logic              miso;
   logic              busy_o;
   logic              done_o;
   logic [DATA_W-1:0] rx_data_o;
   logic              sclk_o;
   logic              cs_n_o;
   logic              mosi_o;
   logic [2:0]        dbg_state_o;

   always #5 clk = ~clk;

   spi_master_ctrl #(
      .DATA_W   (DATA_W),
      .CLK_DIV  (CLK_DIV),
      .CS_SETUP (CS_SETUP),
      .CS_HOLD  (CS_HOLD)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .tx_data_i   (tx_data),
      .hold_cs_i   (hold_cs),
      .abort_i     (abort),
      .miso_i      (miso),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rx_data_o   (rx_data_o),
      .sclk_o      (sclk_o),
      .cs_n_o      (cs_n_o),
      .mosi_o      (mosi_o),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------- slave model ----------------
   // Mode-0 slave: presents the MSB while cs_n is low, advances on each sclk
   // falling edge. Loopback mode simply returns mosi.
   logic              loopback = 1'b1;
   logic [DATA_W-1:0] slave_word = '0;
   int                falls = 0;
   int                fall_base = 0;

   always @(negedge sclk_o) falls = falls + 1;

   assign miso = loopback ? mosi_o
                          : slave_word[DATA_W-1 - ((falls - fall_base) % DATA_W)];

   // ---------------- scoreboard ----------------
   int                n_vec = 0;
   int                n_err = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic              exp_bit_q[$];
   int                rises = 0;

   task automatic check(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // mosi must carry the next expected bit at every sclk rising edge.
   always @(posedge sclk_o) begin
      rises = rises + 1;
      check("sclk_edge_expected", int'(exp_bit_q.size() != 0), 1);
      if (exp_bit_q.size() != 0) check("mosi_bit", mosi_o, exp_bit_q.pop_front());
   end

   // Every done pulse must match the oldest outstanding expected word.
   always @(negedge clk) begin
      logic [DATA_W-1:0] e;
      if (done_o === 1'b1) begin
         check("done_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_rx_data", rx_data_o, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic held_state = 1'b0;
   int   w_lat, w_bad, w_rise0;
   logic w_prev, w_cs0, w_cs_done, w_busy_done, w_sclk_done;
   logic [DATA_W-1:0] w_rx;

   task automatic push_expect(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] rx);
      exp_q.push_back(rx);
      for (int b = DATA_W - 1; b >= 0; b--) exp_bit_q.push_back(tx[b]);
   endtask

   // Start one word in the next cycle and follow it to its done pulse.
   task automatic run_word(input logic [DATA_W-1:0] tx, input logic hold,
                           input logic lb, input logic [DATA_W-1:0] slv);
      @(negedge clk);
      w_prev = held_state;
      w_cs0  = cs_n_o;
      if (!held_state) fall_base = falls;
      start = 1'b1; tx_data = tx; hold_cs = hold; loopback = lb; slave_word = slv;
      push_expect(tx, lb ? tx : slv);
      w_rise0 = rises;
      w_bad = 0;
      w_lat = -1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done_o === 1'b1) begin
            w_lat = c; w_rx = rx_data_o; w_cs_done = cs_n_o;
            w_busy_done = busy_o; w_sclk_done = sclk_o;
            break;
         end
         if (cs_n_o !== 1'b0 || busy_o !== 1'b1) w_bad++;
      end
      held_state = hold;
   endtask

   task automatic check_word(input int exp_lat, input logic [DATA_W-1:0] exp_rx,
                             input logic hold);
      check("latency", w_lat, exp_lat);
      check("rx_data", w_rx, exp_rx);
      check("sclk_rises", rises - w_rise0, DATA_W);
      check("cs_busy_during_word", w_bad, 0);
      check("cs_n_at_start", w_cs0, w_prev ? 0 : 1);
      check("cs_n_at_done", w_cs_done, hold ? 0 : 1);
      check("busy_at_done", w_busy_done, 0);
      check("sclk_at_done", w_sclk_done, 0);
   endtask

   // Reference latency from start-accept to done.
   function automatic int model_lat(input logic from_pause, input logic hold);
      return (from_pause ? 0 : CS_SETUP) + 2 * CLK_DIV * DATA_W
             + (hold ? 0 : CS_HOLD) + 1;
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [DATA_W-1:0] tx;
      logic [DATA_W-1:0] slave;
      logic              lb;
      logic              hold;
      logic [DATA_W-1:0] exp_rx;
      int                exp_lat;
   } vec_t;

   vec_t vecs[8];

   logic [DATA_W-1:0] last_rx;
   int                ndone;

   initial begin
      vecs[0] = '{tx: 8'hA5, slave: 8'h00, lb: 1'b1, hold: 1'b0, exp_rx: 8'hA5, exp_lat: 69};
      vecs[1] = '{tx: 8'hFF, slave: 8'h3C, lb: 1'b0, hold: 1'b0, exp_rx: 8'h3C, exp_lat: 69};
      vecs[2] = '{tx: 8'h12, slave: 8'h00, lb: 1'b1, hold: 1'b1, exp_rx: 8'h12, exp_lat: 67};
      vecs[3] = '{tx: 8'h34, slave: 8'h00, lb: 1'b1, hold: 1'b0, exp_rx: 8'h34, exp_lat: 67};
      vecs[4] = '{tx: 8'h00, slave: 8'h81, lb: 1'b0, hold: 1'b0, exp_rx: 8'h81, exp_lat: 69};
      vecs[5] = '{tx: 8'h5A, slave: 8'hC3, lb: 1'b0, hold: 1'b1, exp_rx: 8'hC3, exp_lat: 67};
      vecs[6] = '{tx: 8'h96, slave: 8'h7E, lb: 1'b0, hold: 1'b1, exp_rx: 8'h7E, exp_lat: 65};
      vecs[7] = '{tx: 8'hE7, slave: 8'h18, lb: 1'b0, hold: 1'b0, exp_rx: 8'h18, exp_lat: 67};

      rst = 1'b1; start = 1'b0; tx_data = '0; hold_cs = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sclk", sclk_o, 0);
      check("rst_cs_n", cs_n_o, 1);
      check("rst_mosi", mosi_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_rx_data", rx_data_o, 0);
      rst = 1'b0;

      // Directed table: loopback, slave data, bursts from PAUSE.
      foreach (vecs[i]) begin
         run_word(vecs[i].tx, vecs[i].hold, vecs[i].lb, vecs[i].slave);
         check_word(vecs[i].exp_lat, vecs[i].exp_rx, vecs[i].hold);
      end

      // Randomized words and bursts against the reference model.
      for (int i = 0; i < 24; i++) begin
         logic [DATA_W-1:0] tx, slv;
         logic hold, lb, prev;
         tx   = DATA_W'($urandom);
         slv  = DATA_W'($urandom);
         lb   = 1'($urandom_range(0, 1));
         hold = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
         prev = held_state;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_word(tx, hold, lb, slv);
         check_word(model_lat(prev, hold), lb ? tx : slv, hold);
      end
      last_rx = w_rx;

      // start held high for the whole word, tx_data changing underneath:
      // one word only, done-cycle start ignored.
      @(negedge clk);
      start = 1'b1; tx_data = 8'hC6; hold_cs = 1'b0; loopback = 1'b1;
      push_expect(8'hC6, 8'hC6);
      for (int c = 1; c <= 71; c++) begin
         @(negedge clk);
         tx_data = DATA_W'($urandom);
         hold_cs = 1'($urandom_range(0, 1));
         if (c == 69) begin
            check("spam_done", done_o, 1);
            check("spam_rx", rx_data_o, 8'hC6);
         end
         if (c == 70) begin
            check("spam_busy_70", busy_o, 0);
            start = 1'b0;
         end
         if (c == 71) check("spam_busy_71", busy_o, 0);
      end
      last_rx = 8'hC6;

      // abort at cycle 30 of a transfer.
      @(negedge clk);
      start = 1'b1; tx_data = 8'h5A; hold_cs = 1'b0; loopback = 1'b1;
      push_expect(8'h5A, 8'h5A);
      for (int c = 1; c <= 31; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 30) abort = 1'b1;
      end
      abort = 1'b0;
      check("abort_cs_n", cs_n_o, 1);
      check("abort_sclk", sclk_o, 0);
      check("abort_busy", busy_o, 0);
      check("abort_mosi", mosi_o, 0);
      exp_q.delete();
      exp_bit_q.delete();
      ndone = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done_o === 1'b1) ndone++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_rx_kept", rx_data_o, last_rx);

      // abort together with start while in PAUSE.
      run_word(8'h77, 1'b1, 1'b1, 8'h00);
      check_word(model_lat(1'b0, 1'b1), 8'h77, 1'b1);
      @(negedge clk);
      abort = 1'b1; start = 1'b1; tx_data = 8'h11; hold_cs = 1'b0;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      held_state = 1'b0;
      check("pause_abort_cs_n", cs_n_o, 1);
      check("pause_abort_busy", busy_o, 0);
      check("pause_abort_done", done_o, 0);
      @(negedge clk);
      check("pause_abort_no_start", busy_o, 0);
      check("pause_abort_rx_kept", rx_data_o, 8'h77);

      // reset at cycle 40, new start at cycle 42.
      @(negedge clk);
      start = 1'b1; tx_data = 8'h3C; hold_cs = 1'b0; loopback = 1'b1;
      push_expect(8'h3C, 8'h3C);
      for (int c = 1; c <= 41; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 40) rst = 1'b1;
      end
      rst = 1'b0;
      check("mid_rst_sclk", sclk_o, 0);
      check("mid_rst_cs_n", cs_n_o, 1);
      check("mid_rst_mosi", mosi_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_done", done_o, 0);
      check("mid_rst_rx_data", rx_data_o, 0);
      exp_q.delete();
      exp_bit_q.delete();
      held_state = 1'b0;
      run_word(8'hD2, 1'b0, 1'b0, 8'h4B);
      check_word(model_lat(1'b0, 1'b0), 8'h4B, 1'b0);

      repeat (4) @(negedge clk);
      check("sb_words_left", exp_q.size(), 0);
      check("sb_bits_left", exp_bit_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard stop in case a wait above never resolves.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
